// File: rtl/tree_sum_sched_if.sv
// tree_sum_sched_if
// Bundles the handshake and operand buses of the tree-adder scheduler.
//   cmd_*  : job command (chunk count) from the layer controller
//   in_*   : 32-operand chunk stream
//   add_op / tree_sum : registered operand bus to, and sum from, the shared adder
//   out_*  : per-job result handshake
//   busy   : scheduler is not idle
// Modports: master = controller/adder side, slave = scheduler.

interface tree_sum_sched_if #(
    parameter int unsigned LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid;
    logic             in_ready;
    logic [511:0]     in_data;
    logic [511:0]     add_op;
    logic [15:0]      tree_sum;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             busy;

    modport master (
        output cmd_valid, cmd_len, in_valid, in_data, tree_sum, out_ready,
        input  cmd_ready, in_ready, add_op, out_valid, out_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_len, in_valid, in_data, tree_sum, out_ready,
        output cmd_ready, in_ready, add_op, out_valid, out_data, busy
    );
endinterface

// File: rtl/tree_sum_sched.sv
// tree_sum_sched
// Time-shares one external 32-input, 16-bit signed combinational tree adder to
// build dot-product sums longer than 32 terms. A job command gives the chunk
// count; chunks are registered onto add_op, and the adder's per-chunk sum is
// accumulated one cycle later into a signed ACC_W accumulator. One 16-bit
// result per job is returned through a valid/ready handshake.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tree_sum_sched_if.slave (command, chunk stream, adder bus, result)
//
// Build option: define TREE_SUM_SCHED_SAT_EN to saturate the final result to
// the 16-bit signed range; otherwise the result is acc[15:0].

module tree_sum_sched #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ACC_W = 24
) (
    input logic              clk,
    input logic              rst_n,
    tree_sum_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } state_e;

    localparam logic [LEN_W-1:0] RemOne = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [511:0]       add_op_q, add_op_d;
    logic               op_vld_q, op_vld_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               out_valid_q, out_valid_d;
    logic [15:0]        out_data_q, out_data_d;

`ifdef TREE_SUM_SCHED_SAT_EN
    // Result fits in 16 signed bits only if bits [ACC_W-1:15] are all equal.
    logic acc_ovf;
    assign acc_ovf = ~((&acc_d[ACC_W-1:15]) | ~(|acc_d[ACC_W-1:15]));
`endif

    always_comb begin
        state_d     = state_q;
        add_op_d    = add_op_q;
        op_vld_d    = 1'b0;
        acc_d       = acc_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        // The adder output belongs to the chunk registered last cycle.
        if (op_vld_q) begin
            acc_d = acc_q + {{(ACC_W-16){bus.tree_sum[15]}}, bus.tree_sum};
        end

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    acc_d = '0;
                    rem_d = bus.cmd_len;
                    if (bus.cmd_len == '0) begin
                        out_data_d  = '0;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StFeed;
                    end
                end
            end
            StFeed: begin
                // Without a handshake add_op holds to avoid toggling the adder.
                if (bus.in_valid) begin
                    add_op_d = bus.in_data;
                    op_vld_d = 1'b1;
                    rem_d    = rem_q - RemOne;
                    if (rem_q == RemOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // acc_d already includes the last chunk here.
`ifdef TREE_SUM_SCHED_SAT_EN
                if (acc_ovf) begin
                    out_data_d = acc_d[ACC_W-1] ? 16'h8000 : 16'h7fff;
                end else begin
                    out_data_d = acc_d[15:0];
                end
`else
                out_data_d = acc_d[15:0];
`endif
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            add_op_q    <= '0;
            op_vld_q    <= 1'b0;
            acc_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            add_op_q    <= add_op_d;
            op_vld_q    <= op_vld_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.in_ready  = (state_q == StFeed);
    assign bus.busy      = (state_q != StIdle);
    assign bus.add_op    = add_op_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_tree_sum_sched.sv
// tb_tree_sum_sched
// Self-checking bench for tree_sum_sched: directed jobs plus randomized jobs
// checked against an arithmetic reference model of the job result. A stub
// combinational adder sums the 32 operands of add_op modulo 2^16.

module tb_tree_sum_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tree_sum_sched_if #(.LEN_W(8)) bus ();

    tree_sum_sched #(
        .LEN_W (8),
        .ACC_W (24)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stub tree adder.
    logic [15:0] stub_sum;
    always_comb begin
        stub_sum = '0;
        for (int k = 0; k < 32; k++) begin
            stub_sum = stub_sum + bus.add_op[16*k +: 16];
        end
    end
    assign bus.tree_sum = stub_sum;

    int in_ready_cnt = 0;
    always @(posedge clk) begin
        if (bus.in_ready) in_ready_cnt <= in_ready_cnt + 1;
    end

    logic [511:0] chunk_mem [256];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [511:0] got,
                            input logic [511:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_chunk();
        logic [511:0] c;
        for (int w = 0; w < 16; w++) c[32*w +: 32] = $urandom();
        return c;
    endfunction

    function automatic logic [511:0] chunk_with_sum(input int target);
        logic [511:0] c;
        int others;
        c = rand_chunk();
        others = 0;
        for (int k = 1; k < 32; k++) others += int'($signed(c[16*k +: 16]));
        c[15:0] = 16'(target - others);
        return c;
    endfunction

    // Reference: sum each chunk in plain integers, wrap to 16 bits (adder),
    // accumulate, wrap to 24 bits, then take the 16-bit result.
    function automatic logic [15:0] model(input int len);
        int acc;
        int s;
        int a;
        logic [15:0] s16;
        logic [23:0] a24;
        acc = 0;
        for (int i = 0; i < len; i++) begin
            s = 0;
            for (int k = 0; k < 32; k++) s += int'($signed(chunk_mem[i][16*k +: 16]));
            s16 = s[15:0];
            acc += int'($signed(s16));
        end
        a24 = acc[23:0];
        a = int'($signed(a24));
`ifdef TREE_SUM_SCHED_SAT_EN
        if (a > 32767) return 16'h7fff;
        if (a < -32768) return 16'h8000;
`endif
        return a[15:0];
    endfunction

    task automatic start_cmd(input int len);
        check_eq("cmd_ready_idle", bus.cmd_ready, 1);
        check_eq("busy_idle", bus.busy, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'(len);
        tick();
        bus.cmd_valid = 1'b0;
        check_eq("busy_job", bus.busy, 1);
    endtask

    task automatic feed_chunk(input int i, input int gap);
        int guard;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        if (gap > 0 && i > 0) check_eq("add_op_hold", bus.add_op, chunk_mem[i-1]);
        bus.in_valid = 1'b1;
        bus.in_data  = chunk_mem[i];
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_eq("in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check_eq("add_op", bus.add_op, chunk_mem[i]);
    endtask

    task automatic hold_and_accept(input logic [15:0] exp, input int hold);
        check_eq("out_valid", bus.out_valid, 1);
        check_eq("out_data", bus.out_data, exp);
        // A command offered while the result waits must be ignored.
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd7;
        bus.out_ready = 1'b0;
        repeat (hold) begin
            tick();
            check_eq("hold_valid", bus.out_valid, 1);
            check_eq("hold_data", bus.out_data, exp);
            check_eq("hold_cmd_ready", bus.cmd_ready, 0);
        end
        bus.cmd_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("accept_valid", bus.out_valid, 0);
        check_eq("accept_cmd_ready", bus.cmd_ready, 1);
        check_eq("accept_busy", bus.busy, 0);
    endtask

    task automatic run_job(input int len, input int gap, input int hold,
                           input logic [15:0] exp);
        int rc0;
        rc0 = in_ready_cnt;
        start_cmd(len);
        if (len > 0) begin
            for (int i = 0; i < len; i++) feed_chunk(i, gap);
            // Handshake cycle, then DRAIN, then the result cycle.
            check_eq("drain_no_valid", bus.out_valid, 0);
            tick();
        end
        hold_and_accept(exp, hold);
        if (gap == 0) check_eq("in_ready_cycles", in_ready_cnt - rc0, len);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_pos;
        logic [15:0] exp_neg;
        int len;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        check_eq("rst_cmd_ready", bus.cmd_ready, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_add_op", bus.add_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single chunk, all operands 1.
        for (int k = 0; k < 32; k++) chunk_mem[0][16*k +: 16] = 16'd1;
        run_job(1, 0, 0, 16'd32);

        // Streaming job.
        chunk_mem[0] = chunk_with_sum(100);
        chunk_mem[1] = chunk_with_sum(-50);
        chunk_mem[2] = chunk_with_sum(7);
        chunk_mem[3] = chunk_with_sum(3);
        run_job(4, 0, 0, 16'd60);

        // Bubbles and backpressure.
        for (int i = 0; i < 3; i++) chunk_mem[i] = chunk_with_sum(1234);
        run_job(3, 2, 5, 16'd3702);

        // Zero length.
        run_job(0, 0, 2, 16'd0);

        // Overflow both directions.
`ifdef TREE_SUM_SCHED_SAT_EN
        exp_pos = 16'h7fff;
        exp_neg = 16'h8000;
`else
        exp_pos = 16'h5f90;
        exp_neg = 16'ha070;
`endif
        for (int i = 0; i < 3; i++) chunk_mem[i] = chunk_with_sum(30000);
        run_job(3, 0, 1, exp_pos);
        for (int i = 0; i < 3; i++) chunk_mem[i] = chunk_with_sum(-30000);
        run_job(3, 0, 1, exp_neg);

        // Reset mid-job.
        for (int i = 0; i < 5; i++) chunk_mem[i] = chunk_with_sum(1000 + i);
        start_cmd(5);
        feed_chunk(0, 0);
        feed_chunk(1, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_cmd_ready", bus.cmd_ready, 1);
        check_eq("midrst_busy", bus.busy, 0);
        check_eq("midrst_out_valid", bus.out_valid, 0);
        check_eq("midrst_in_ready", bus.in_ready, 0);
        check_eq("midrst_add_op", bus.add_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chunk_mem[0] = chunk_with_sum(5);
        run_job(1, 0, 0, 16'd5);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) chunk_mem[i] = rand_chunk();
            run_job(len, $urandom_range(0, 2), $urandom_range(0, 3), model(len));
        end

        // Maximum length.
        for (int i = 0; i < 255; i++) chunk_mem[i] = rand_chunk();
        run_job(255, 0, 1, model(255));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
